// File: rtl/solver_sequencer.sv
// Escape-time solver control sequencer: ABS pass, triangular limb-product schedule, flushes, divergence check.
// Optional feature macro: SOLVER_SEQUENCER_ABORT_EN enables the abort input.
module solver_sequencer #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int ITER_BITS       = 16,
  parameter int FLUSH_WAIT      = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       cfg_wr_en,
  input  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs,
  input  logic [ITER_BITS-1:0]       cfg_iter_limit,
  input  logic                       cfg_mode,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       zre_sign,
  input  logic                       zim_sign,
  input  logic                       diverged,
  output logic                       busy,
  output logic                       abs_en,
  output logic [LIMB_INDEX_BITS-1:0] abs_ind,
  output logic                       abs_first,
  output logic                       abs_re_neg,
  output logic                       abs_im_neg,
  output logic                       mul_en,
  output logic [LIMB_INDEX_BITS-1:0] mul_col,
  output logic [LIMB_INDEX_BITS-1:0] mul_a_ind,
  output logic [LIMB_INDEX_BITS-1:0] mul_b_ind,
  output logic                       mul_col_first,
  output logic                       mul_diag,
  output logic                       mul_im_neg,
  output logic                       col_wr_en,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [ITER_BITS-1:0]       result_count,
  output logic                       result_escaped
);

  localparam int FW_BITS = $clog2(FLUSH_WAIT + 2);
  localparam logic [FW_BITS-1:0]         FW_LOAD  = FW_BITS'(FLUSH_WAIT);
  localparam logic [FW_BITS-1:0]         FW_ONE   = FW_BITS'(1);
  localparam logic [LIMB_INDEX_BITS-1:0] LIMB_ONE = LIMB_INDEX_BITS'(1);
  localparam logic [ITER_BITS-1:0]       ITER_ONE = ITER_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ABS, S_ABS_FLUSH, S_MUL, S_MUL_FLUSH, S_CHECK, S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [LIMB_INDEX_BITS-1:0] n_q, n_d, idx_q, idx_d, col_q, col_d, p_q, p_d;
  logic                       flip_q, flip_d;
  logic [FW_BITS-1:0]         flush_q, flush_d;
  logic [ITER_BITS-1:0]       lim_q, lim_d, count_q, count_d;
  logic                       mode_q, mode_d, re_neg_q, re_neg_d, im_neg_q, im_neg_d;
  logic                       esc_q, esc_d;
  logic                       begin_iter, begin_mul, col_last;
  logic [LIMB_INDEX_BITS-1:0] a_ind, b_ind;

  assign col_last = (p_q == (col_q >> 1));
  assign a_ind    = flip_q ? p_q : col_q - p_q;
  assign b_ind    = flip_q ? col_q - p_q : p_q;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    col_d      = col_q;
    p_d        = p_q;
    flip_d     = flip_q;
    flush_d    = flush_q;
    lim_d      = lim_q;
    count_d    = count_q;
    mode_d     = mode_q;
    re_neg_d   = re_neg_q;
    im_neg_d   = im_neg_q;
    esc_d      = esc_q;
    begin_iter = 1'b0;
    begin_mul  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_wr_en) begin
          n_d    = (cfg_num_limbs == '0) ? LIMB_ONE : cfg_num_limbs;
          lim_d  = cfg_iter_limit;
          mode_d = cfg_mode;
        end
        if (start) begin
          count_d    = '0;
          re_neg_d   = 1'b0;
          im_neg_d   = 1'b0;
          esc_d      = 1'b0;
          begin_iter = 1'b1;
        end
      end
      S_ABS: begin
        if (idx_q == '0) begin
          state_d = S_ABS_FLUSH;
          flush_d = FW_LOAD;
        end else begin
          idx_d = idx_q - LIMB_ONE;
        end
      end
      S_ABS_FLUSH: begin
        if (flush_q == '0) begin_mul = 1'b1;
        else               flush_d   = flush_q - FW_ONE;
      end
      // Each (column, p) pair issues two products: straight, then operands swapped.
      S_MUL: begin
        if (!flip_q) begin
          flip_d = 1'b1;
        end else begin
          flip_d = 1'b0;
          if (!col_last) begin
            p_d = p_q + LIMB_ONE;
          end else if (col_q == '0) begin
            state_d = S_MUL_FLUSH;
            flush_d = FW_LOAD;
          end else begin
            col_d = col_q - LIMB_ONE;
            p_d   = '0;
          end
        end
      end
      S_MUL_FLUSH: begin
        if (flush_q == '0) state_d = S_CHECK;
        else               flush_d = flush_q - FW_ONE;
      end
      S_CHECK: begin
        re_neg_d = zre_sign;
        im_neg_d = zim_sign;
        if (diverged) begin
          esc_d   = 1'b1;
          state_d = S_DONE;
        end else if (count_q == lim_q) begin
          count_d = '1;
          esc_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          count_d    = count_q + ITER_ONE;
          begin_iter = 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (begin_iter && mode_q) begin
      state_d = S_ABS;
      idx_d   = n_q - LIMB_ONE;
    end else if (begin_iter || begin_mul) begin
      state_d = S_MUL;
      col_d   = n_q;
      p_d     = '0;
      flip_d  = 1'b0;
    end

`ifdef SOLVER_SEQUENCER_ABORT_EN
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      count_d = '0;
    end
`endif
  end

`ifndef SOLVER_SEQUENCER_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      n_q      <= LIMB_ONE;
      idx_q    <= '0;
      col_q    <= '0;
      p_q      <= '0;
      flip_q   <= 1'b0;
      flush_q  <= '0;
      lim_q    <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      re_neg_q <= 1'b0;
      im_neg_q <= 1'b0;
      esc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      col_q    <= col_d;
      p_q      <= p_d;
      flip_q   <= flip_d;
      flush_q  <= flush_d;
      lim_q    <= lim_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      re_neg_q <= re_neg_d;
      im_neg_q <= im_neg_d;
      esc_q    <= esc_d;
    end
  end

  // Indices and result fields read zero outside the phase that qualifies them.
  assign busy           = (state_q != S_IDLE);
  assign abs_en         = (state_q == S_ABS);
  assign abs_ind        = abs_en ? idx_q : '0;
  assign abs_first      = abs_en && (idx_q == n_q - LIMB_ONE);
  assign abs_re_neg     = re_neg_q;
  assign abs_im_neg     = im_neg_q;
  assign mul_en         = (state_q == S_MUL);
  assign mul_col        = mul_en ? col_q : '0;
  assign mul_a_ind      = mul_en ? a_ind : '0;
  assign mul_b_ind      = mul_en ? b_ind : '0;
  assign mul_col_first  = mul_en && (p_q == '0) && !flip_q;
  assign mul_diag       = mul_en && (a_ind == b_ind);
  assign mul_im_neg     = mode_q & (re_neg_q ^ im_neg_q);
  assign col_wr_en      = mul_en && flip_q && col_last && (col_q < n_q);
  assign result_valid   = (state_q == S_DONE);
  assign result_count   = result_valid ? count_q : '0;
  assign result_escaped = result_valid && esc_q;

endmodule

// File: tb/tb_solver_sequencer.sv
// Bench for solver_sequencer: per-cycle trace model built from the iteration rules, plus literal pins.
`timescale 1ns/1ps
module tb_solver_sequencer;

  localparam int FW = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [5:0]  cfg_num_limbs = '0;
  logic [15:0] cfg_iter_limit = '0;
  logic        cfg_mode = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        zre_sign = 1'b0;
  logic        zim_sign = 1'b0;
  logic        diverged = 1'b0;
  logic        result_ready = 1'b0;
  logic        busy, abs_en, abs_first, abs_re_neg, abs_im_neg;
  logic        mul_en, mul_col_first, mul_diag, mul_im_neg, col_wr_en;
  logic        result_valid, result_escaped;
  logic [5:0]  abs_ind, mul_col, mul_a_ind, mul_b_ind;
  logic [15:0] result_count;

  solver_sequencer #(.LIMB_INDEX_BITS(6), .ITER_BITS(16), .FLUSH_WAIT(FW)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_wr_en(cfg_wr_en), .cfg_num_limbs(cfg_num_limbs),
    .cfg_iter_limit(cfg_iter_limit), .cfg_mode(cfg_mode), .start(start), .abort(abort),
    .zre_sign(zre_sign), .zim_sign(zim_sign), .diverged(diverged), .busy(busy),
    .abs_en(abs_en), .abs_ind(abs_ind), .abs_first(abs_first), .abs_re_neg(abs_re_neg),
    .abs_im_neg(abs_im_neg), .mul_en(mul_en), .mul_col(mul_col), .mul_a_ind(mul_a_ind),
    .mul_b_ind(mul_b_ind), .mul_col_first(mul_col_first), .mul_diag(mul_diag),
    .mul_im_neg(mul_im_neg), .col_wr_en(col_wr_en), .result_valid(result_valid),
    .result_ready(result_ready), .result_count(result_count), .result_escaped(result_escaped)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        busy, abs_en, abs_first, re_neg, im_neg;
    logic        mul_en, col_first, diag, mul_imneg, col_wr, valid, escaped;
    logic [5:0]  abs_ind, col, a, b;
    logic [15:0] count;
    logic        div, zre, zim;
  } rec_t;

  rec_t        q[$];
  rec_t        cur;
  int          total = 0;
  int          bad = 0;
  int          cap_a[$], cap_b[$], cap_abs[$];
  int          imneg_cnt, first_cnt;
  logic [15:0] fin_cnt;
  logic        fin_esc, fin_re, fin_im;
  logic        lat_re = 1'b0, lat_im = 1'b0, lat_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  function automatic rec_t blank(input logic bsy, input logic re, input logic im, input logic mode);
    rec_t r;
    r = '0;
    r.busy = bsy;
    r.re_neg = re;
    r.im_neg = im;
    r.mul_imneg = mode & (re ^ im);
    return r;
  endfunction

  // Expected trace of a whole solve, derived from the iteration rules.
  task automatic build(input int n, input int l, input logic mode, input int div_at,
                       input logic zre_v, input logic zim_v);
    int cnt = 0;
    int it = 0;
    logic re = 1'b0, im = 1'b0;
    bit fin = 0;
    rec_t r;
    q.delete();
    while (!fin) begin
      if (mode) begin
        for (int i = n - 1; i >= 0; i--) begin
          r = blank(1, re, im, mode);
          r.abs_en = 1; r.abs_ind = 6'(i); r.abs_first = (i == n - 1);
          q.push_back(r);
        end
        for (int i = 0; i <= FW; i++) q.push_back(blank(1, re, im, mode));
      end
      for (int k = n; k >= 0; k--)
        for (int p = 0; p <= k / 2; p++)
          for (int f = 0; f < 2; f++) begin
            r = blank(1, re, im, mode);
            r.mul_en = 1; r.col = 6'(k);
            r.a = 6'(f ? p : k - p);
            r.b = 6'(f ? k - p : p);
            r.col_first = (p == 0 && f == 0);
            r.diag = (r.a == r.b);
            r.col_wr = (f == 1 && p == k / 2 && k < n);
            q.push_back(r);
          end
      for (int i = 0; i <= FW; i++) q.push_back(blank(1, re, im, mode));
      r = blank(1, re, im, mode);
      r.div = (it == div_at); r.zre = zre_v; r.zim = zim_v;
      q.push_back(r);
      re = zre_v; im = zim_v;
      if (it == div_at) begin fin = 1; fin_esc = 1; fin_cnt = 16'(cnt); end
      else if (cnt == l) begin fin = 1; fin_esc = 0; fin_cnt = 16'hFFFF; end
      else cnt++;
      it++;
    end
    fin_re = re; fin_im = im;
  endtask

  task automatic step();
    @(negedge clock);
    chk("busy", busy, cur.busy);
    chk("abs_en", abs_en, cur.abs_en);
    chk("mul_en", mul_en, cur.mul_en);
    chk("col_wr_en", col_wr_en, cur.col_wr);
    chk("abs_re_neg", abs_re_neg, cur.re_neg);
    chk("abs_im_neg", abs_im_neg, cur.im_neg);
    chk("mul_im_neg", mul_im_neg, cur.mul_imneg);
    chk("result_valid", result_valid, cur.valid);
    if (cur.abs_en) begin
      chk("abs_ind", abs_ind, cur.abs_ind);
      chk("abs_first", abs_first, cur.abs_first);
    end
    if (cur.mul_en) begin
      chk("mul_col", mul_col, cur.col);
      chk("mul_a_ind", mul_a_ind, cur.a);
      chk("mul_b_ind", mul_b_ind, cur.b);
      chk("mul_col_first", mul_col_first, cur.col_first);
      chk("mul_diag", mul_diag, cur.diag);
    end
    if (cur.valid) begin
      chk("result_count", result_count, cur.count);
      chk("result_escaped", result_escaped, cur.escaped);
    end
    if (mul_en) begin
      cap_a.push_back(int'(mul_a_ind));
      cap_b.push_back(int'(mul_b_ind));
      if (mul_im_neg) imneg_cnt++;
    end
    if (abs_en) begin
      cap_abs.push_back(int'(abs_ind));
      if (abs_first) first_cnt++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    cur = blank(0, lat_re, lat_im, lat_mode);
    step();
  endtask

  task automatic configure(input int n, input int l, input logic m);
    cfg_num_limbs = 6'(n); cfg_iter_limit = 16'(l); cfg_mode = m; cfg_wr_en = 1;
    idle_cycle();
    cfg_wr_en = 0;
    lat_mode = m;
  endtask

  task automatic kick();
    cap_a.delete(); cap_b.delete(); cap_abs.delete();
    imneg_cnt = 0; first_cnt = 0;
    start = 1;
    idle_cycle();
    start = 0;
    lat_re = 0; lat_im = 0;
  endtask

  task automatic run(input int abort_at, output bit aborted);
    aborted = 0;
    for (int i = 0; i < q.size(); i++) begin
      diverged = q[i].div; zre_sign = q[i].zre; zim_sign = q[i].zim;
      abort = (i == abort_at);
      cur = q[i];
      step();
`ifdef SOLVER_SEQUENCER_ABORT_EN
      if (i == abort_at) begin
        abort = 0;
        cur = blank(0, q[i].re_neg, q[i].im_neg, lat_mode);
        lat_re = q[i].re_neg; lat_im = q[i].im_neg;
        step();
        aborted = 1;
        break;
      end
`endif
    end
    abort = 0; diverged = 0; zre_sign = 0; zim_sign = 0;
  endtask

  task automatic done_phase(input int hold, input bit poke);
    rec_t d;
    d = blank(1, fin_re, fin_im, lat_mode);
    d.valid = 1; d.count = fin_cnt; d.escaped = fin_esc;
    for (int i = 0; i < hold; i++) begin
      result_ready = 0;
      start = poke & i[0];
      cfg_wr_en = poke & i[0];
      cfg_num_limbs = 6'd5; cfg_mode = 1; cfg_iter_limit = 16'd7;
      cur = d;
      step();
    end
    start = 0; cfg_wr_en = 0; result_ready = 1;
    cur = d;
    step();
    result_ready = 0;
    lat_re = fin_re; lat_im = fin_im;
    idle_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ab;
    int exp_a[4];
    int exp_b[4];
    int exp_abs[4];
    exp_a = '{1, 0, 0, 0};
    exp_b = '{0, 1, 0, 0};
    exp_abs = '{1, 0, 1, 0};

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);          chk("rst_abs_en", abs_en, 0);
    chk("rst_abs_ind", abs_ind, 0);    chk("rst_abs_first", abs_first, 0);
    chk("rst_re_neg", abs_re_neg, 0);  chk("rst_im_neg", abs_im_neg, 0);
    chk("rst_mul_en", mul_en, 0);      chk("rst_mul_col", mul_col, 0);
    chk("rst_mul_a", mul_a_ind, 0);    chk("rst_mul_b", mul_b_ind, 0);
    chk("rst_col_first", mul_col_first, 0); chk("rst_diag", mul_diag, 0);
    chk("rst_imneg", mul_im_neg, 0);   chk("rst_col_wr", col_wr_en, 0);
    chk("rst_valid", result_valid, 0); chk("rst_count", result_count, 0);
    chk("rst_escaped", result_escaped, 0);
    @(posedge clock); #1;
    reset_n = 1;
    idle_cycle();

    // Default config: N=1, L=0, mode 0.
    build(1, 0, 0, -1, 0, 0);
    chk("n1_trace_len", q.size(), 10);
    kick();
    run(-1, ab);
    chk("n1_mul_cycles", cap_a.size(), 4);
    for (int i = 0; i < 4 && i < cap_a.size(); i++) begin
      chk("n1_a_seq", cap_a[i], exp_a[i]);
      chk("n1_b_seq", cap_b[i], exp_b[i]);
    end
    done_phase(2, 0);

    // N=2, L=3, mode 0, no divergence; DONE held with start/cfg pokes.
    configure(2, 3, 0);
    build(2, 3, 0, -1, 0, 0);
    chk("n2_trace_len", q.size(), 56);
    chk("n2_model_cnt", fin_cnt, 16'hFFFF);
    kick();
    run(-1, ab);
    done_phase(10, 1);

    // Config pokes in DONE ignored; divergence at second CHECK.
    build(2, 3, 0, 1, 0, 0);
    chk("div_model_cnt", fin_cnt, 1);
    chk("div_model_esc", fin_esc, 1);
    kick();
    run(-1, ab);
    done_phase(1, 0);

    // Burning Ship: signs latched at CHECK drive the next iteration.
    configure(2, 1, 1);
    build(2, 1, 1, -1, 1, 0);
    chk("bs_trace_len", q.size(), 42);
    kick();
    run(-1, ab);
    chk("bs_abs_cycles", cap_abs.size(), 4);
    for (int i = 0; i < 4 && i < cap_abs.size(); i++) chk("bs_abs_seq", cap_abs[i], exp_abs[i]);
    chk("bs_abs_first_cnt", first_cnt, 2);
    chk("bs_imneg_cnt", imneg_cnt, 8);
    done_phase(3, 0);

    // Reset asserted mid-solve.
    configure(2, 3, 0);
    build(2, 3, 0, -1, 0, 0);
    kick();
    for (int i = 0; i < 6; i++) begin cur = q[i]; step(); end
    reset_n = 0;
    #2;
    chk("mrst_busy", busy, 0);
    chk("mrst_mul_en", mul_en, 0);
    chk("mrst_valid", result_valid, 0);
    @(posedge clock); #1;
    reset_n = 1;
    lat_re = 0; lat_im = 0; lat_mode = 0;
    idle_cycle();

    // Abort during MUL.
    configure(2, 0, 0);
    build(2, 0, 0, -1, 0, 0);
    kick();
    run(3, ab);
    if (ab) begin
      @(negedge clock);
      chk("abort_busy", busy, 0);
      chk("abort_valid", result_valid, 0);
      @(posedge clock); #1;
    end else begin
      done_phase(1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
